// File: rtl/axi_write_arbiter.sv
// rtl/axi_write_arbiter.sv - two-master round-robin write arbiter for one AW/W/B slave port
// W and B are steered by order FIFOs that record the master of each granted AW.

module axi_write_arbiter_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic din,
  input  logic pop,
  output logic head,
  output logic empty,
  output logic full
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] mem;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // Entry storage needs no reset: it is only read when count says it is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));
endmodule

module axi_write_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2*ADDR_W-1:0] m_awaddr,
  input  logic [1:0]          m_awvalid,
  output logic [1:0]          m_awready,
  input  logic [2*DATA_W-1:0] m_wdata,
  input  logic [1:0]          m_wvalid,
  output logic [1:0]          m_wready,
  output logic [1:0]          m_bvalid,
  input  logic [1:0]          m_bready,
  output logic [ADDR_W-1:0]   s_awaddr,
  output logic                s_awvalid,
  input  logic                s_awready,
  output logic [DATA_W-1:0]   s_wdata,
  output logic                s_wvalid,
  input  logic                s_wready,
  input  logic                s_bvalid,
  output logic                s_bready,
  output logic                b_orphan
);
  typedef enum logic {IDLE, LOCK} state_t;

  state_t state_q, state_d;
  logic   grant_q, grant_d;
  logic   rr_q, rr_d;
  logic   aw_push;
  logic   w_pop, b_pop;
  logic   wq_head, wq_empty, wq_full;
  logic   bq_head, bq_empty, bq_full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    aw_push   = 1'b0;
    s_awvalid = 1'b0;
    m_awready = 2'b00;
    s_awaddr  = grant_q ? m_awaddr[2*ADDR_W-1:ADDR_W] : m_awaddr[ADDR_W-1:0];
    case (state_q)
      IDLE: begin
        // Granting only when both FIFOs have room keeps pushes from ever overflowing.
        if ((|m_awvalid) && !wq_full && !bq_full) begin
          state_d = LOCK;
          grant_d = m_awvalid[rr_q] ? rr_q : ~rr_q;
        end
      end
      LOCK: begin
        s_awvalid          = m_awvalid[grant_q];
        m_awready[grant_q] = s_awready;
        if (m_awvalid[grant_q] && s_awready) begin
          aw_push = 1'b1;
          rr_d    = ~grant_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_wvalid = !wq_empty && m_wvalid[wq_head];
    s_wdata  = wq_head ? m_wdata[2*DATA_W-1:DATA_W] : m_wdata[DATA_W-1:0];
    m_wready = 2'b00;
    m_wready[wq_head] = !wq_empty && s_wready;
    w_pop    = s_wvalid && s_wready;

    m_bvalid = 2'b00;
    m_bvalid[bq_head] = !bq_empty && s_bvalid;
    s_bready = !bq_empty && m_bready[bq_head];
    b_pop    = s_bvalid && s_bready;
    b_orphan = s_bvalid && bq_empty;
  end

  axi_write_arbiter_fifo #(.DEPTH(DEPTH)) u_wq (
    .clk(clk), .rst(rst), .push(aw_push), .din(grant_q), .pop(w_pop),
    .head(wq_head), .empty(wq_empty), .full(wq_full)
  );

  axi_write_arbiter_fifo #(.DEPTH(DEPTH)) u_bq (
    .clk(clk), .rst(rst), .push(aw_push), .din(grant_q), .pop(b_pop),
    .head(bq_head), .empty(bq_empty), .full(bq_full)
  );
endmodule

// File: tb/tb_axi_write_arbiter.sv
// tb/tb_axi_write_arbiter.sv - directed bench for axi_write_arbiter with a queue-based reference model
// Masters and slave are driven from job queues; a model of grant order is checked every cycle.

module tb_axi_write_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [2*AW-1:0] m_awaddr;
  logic [1:0]    m_awvalid, m_awready;
  logic [2*DW-1:0] m_wdata;
  logic [1:0]    m_wvalid, m_wready, m_bvalid, m_bready;
  logic [AW-1:0] s_awaddr;
  logic          s_awvalid, s_awready;
  logic [DW-1:0] s_wdata;
  logic          s_wvalid, s_wready, s_bvalid, s_bready, b_orphan;

  always #5 clk = ~clk;

  axi_write_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_bready(m_bready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .b_orphan(b_orphan)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] ctrl_act();
    return {s_awvalid, m_awready, s_wvalid, m_wready, m_bvalid, s_bready, b_orphan};
  endfunction

  logic [31:0] aw_q0[$], aw_q1[$], w_q0[$], w_q1[$];
  int          aw_log_m[$], b_log[$];
  logic [31:0] aw_log_a[$], w_log[$];
  int          credit = 0;
  int          cyc = 0;
  bit          b_en = 1'b1, wready_en = 1'b1, force_b = 1'b0, slow_aw = 1'b0;

  // Master and slave pin driver: sample handshakes at negedge, drive just after posedge.
  initial begin
    m_awaddr = '0; m_awvalid = '0; m_wdata = '0; m_wvalid = '0; m_bready = 2'b11;
    s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0;
    forever begin
      @(negedge clk);
      if (m_awvalid[0] && m_awready[0] && aw_q0.size() > 0) begin void'(aw_q0.pop_front()); aw_log_m.push_back(0); end
      if (m_awvalid[1] && m_awready[1] && aw_q1.size() > 0) begin void'(aw_q1.pop_front()); aw_log_m.push_back(1); end
      if (s_awvalid && s_awready) aw_log_a.push_back(s_awaddr);
      if (m_wvalid[0] && m_wready[0] && w_q0.size() > 0) void'(w_q0.pop_front());
      if (m_wvalid[1] && m_wready[1] && w_q1.size() > 0) void'(w_q1.pop_front());
      if (s_wvalid && s_wready) begin w_log.push_back(s_wdata); credit++; end
      for (int m = 0; m < 2; m++) if (m_bvalid[m] && m_bready[m]) b_log.push_back(m);
      if (s_bvalid && s_bready) credit--;
      @(posedge clk);
      #1;
      cyc++;
      m_awvalid[0] = rst && aw_q0.size() > 0;
      m_awvalid[1] = rst && aw_q1.size() > 0;
      m_awaddr[31:0]  = aw_q0.size() > 0 ? aw_q0[0] : '0;
      m_awaddr[63:32] = aw_q1.size() > 0 ? aw_q1[0] : '0;
      m_wvalid[0] = rst && w_q0.size() > 0;
      m_wvalid[1] = rst && w_q1.size() > 0;
      m_wdata[31:0]  = w_q0.size() > 0 ? w_q0[0] : '0;
      m_wdata[63:32] = w_q1.size() > 0 ? w_q1[0] : '0;
      s_awready = slow_aw ? cyc[0] : 1'b1;
      s_wready  = wready_en;
      s_bvalid  = force_b || (b_en && credit > 0);
      force_b   = 1'b0;
    end
  end

  // Reference model: a pending grant plus two queues of master ids in grant order.
  int pend = -1;
  int rr = 0;
  int mwq[$], mbq[$];
  int nw, nb;
  bit aw_hs, w_hs, b_hs;

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        pend = -1; rr = 0; mwq.delete(); mbq.delete();
      end else begin
        nw = mwq.size(); nb = mbq.size();
        aw_hs = pend >= 0 && m_awvalid[pend] && s_awready;
        w_hs  = nw > 0 && m_wvalid[mwq[0]] && s_wready;
        b_hs  = nb > 0 && s_bvalid && m_bready[mbq[0]];
        if (w_hs) void'(mwq.pop_front());
        if (b_hs) void'(mbq.pop_front());
        if (aw_hs) begin
          mwq.push_back(pend); mbq.push_back(pend);
          rr = 1 - pend; pend = -1;
        end else if (pend < 0 && m_awvalid != 2'b00 && nw < DEPTH && nb < DEPTH) begin
          pend = m_awvalid[rr] ? rr : 1 - rr;
        end
      end
    end
  end

  logic       e_awv, e_wv, e_br, e_orph;
  logic [1:0] e_awr, e_wr, e_bv;
  logic [31:0] e_wdata;

  initial begin
    forever begin
      @(negedge clk);
      e_awv = 1'b0; e_awr = 2'b00; e_wv = 1'b0; e_wr = 2'b00; e_bv = 2'b00; e_br = 1'b0; e_orph = 1'b0;
      e_wdata = '0;
      if (pend >= 0) begin
        e_awv = m_awvalid[pend];
        e_awr[pend] = s_awready;
      end
      if (mwq.size() > 0) begin
        e_wv = m_wvalid[mwq[0]];
        e_wr[mwq[0]] = s_wready;
        e_wdata = mwq[0] == 1 ? m_wdata[63:32] : m_wdata[31:0];
      end
      if (mbq.size() > 0) begin
        e_bv[mbq[0]] = s_bvalid;
        e_br = m_bready[mbq[0]];
      end else begin
        e_orph = s_bvalid;
      end
      chk("model_ctrl", ctrl_act(), {e_awv, e_awr, e_wv, e_wr, e_bv, e_br, e_orph});
      if (e_awv) chk("model_awaddr", s_awaddr, (pend == 1) ? m_awaddr[63:32] : m_awaddr[31:0]);
      if (e_wv)  chk("model_wdata", s_wdata, e_wdata);
    end
  end

  task automatic clear_all();
    aw_q0.delete(); aw_q1.delete(); w_q0.delete(); w_q1.delete();
    aw_log_m.delete(); aw_log_a.delete(); w_log.delete(); b_log.delete();
    credit = 0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b0;
    clear_all();
    repeat (2) @(negedge clk);
    chk("reset_ctrl", ctrl_act(), 10'd0);
    rst = 1'b1;
  endtask

  task automatic wait_b(input int n);
    int k = 0;
    while (b_log.size() < n && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("wait_b_done", b_log.size() >= n, 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset_dut();

    // Test 1: single m0 write, grant one cycle after awvalid
    @(negedge clk);
    aw_q0.push_back(32'h100); w_q0.push_back(32'h123);
    k = 0;
    while (!m_awvalid[0] && k < 10) begin @(negedge clk); k++; end
    chk("t1_bubble", s_awvalid, 0);
    @(negedge clk);
    chk("t1_awaddr", {s_awvalid, s_awaddr}, {1'b1, 32'h100});
    wait_b(1);
    chk("t1_wdata", w_log[0], 32'h123);
    chk("t1_b_master", {b_log.size(), b_log[0]}, {32'd1, 32'd0});

    // Test 2: simultaneous requests, two each, slow AW ready
    reset_dut();
    @(negedge clk);
    slow_aw = 1'b1;
    aw_q0.push_back(32'h1000); aw_q0.push_back(32'h1004);
    aw_q1.push_back(32'h2000); aw_q1.push_back(32'h2004);
    w_q0.push_back(32'hA0); w_q0.push_back(32'hA1);
    w_q1.push_back(32'hB0); w_q1.push_back(32'hB1);
    wait_b(4);
    slow_aw = 1'b0;
    chk("t2_grant_order", {aw_log_m[0][1:0], aw_log_m[1][1:0], aw_log_m[2][1:0], aw_log_m[3][1:0]}, 8'b00_01_00_01);
    chk("t2_addr_order", {aw_log_a[0][15:0], aw_log_a[1][15:0], aw_log_a[2][15:0], aw_log_a[3][15:0]},
        64'h1000_2000_1004_2004);
    chk("t2_wdata_order", {w_log[0][7:0], w_log[1][7:0], w_log[2][7:0], w_log[3][7:0]}, 32'hA0B0A1B1);
    chk("t2_b_order", {b_log[0][1:0], b_log[1][1:0], b_log[2][1:0], b_log[3][1:0]}, 8'b00_01_00_01);

    // Test 3: W from m1 presented three cycles before its AW
    @(negedge clk);
    w_q1.push_back(32'h456);
    repeat (3) begin
      @(negedge clk);
      chk("t3_wready_stall", {m_wvalid[1], m_wready[1]}, 2'b10);
    end
    aw_q1.push_back(32'h200);
    wait_b(5);
    chk("t3_awaddr", aw_log_a[$], 32'h200);
    chk("t3_wdata", w_log[$], 32'h456);
    chk("t3_b_master", b_log[$], 1);

    // Test 4: B withheld, five m0 writes against four order-FIFO entries
    @(negedge clk);
    b_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      aw_q0.push_back(32'h400 + 32'(4 * i));
      w_q0.push_back(32'h40 + 32'(i));
    end
    repeat (20) @(negedge clk);
    chk("t4_aw_accepted", aw_log_m.size(), 9);
    chk("t4_fifth_waiting", {aw_q0.size(), 30'd0, m_awvalid[0], m_awready[0]}, {32'd1, 30'd0, 2'b10});
    b_en = 1'b1;
    wait_b(10);
    chk("t4_all_done", {aw_log_m.size(), w_log.size()}, {32'd10, 32'd10});
    chk("t4_last_addr", aw_log_a[$], 32'h410);

    // Test 5: orphan B response
    @(negedge clk);
    force_b = 1'b1;
    @(negedge clk);
    chk("t5_orphan", {s_bvalid, s_bready, b_orphan, m_bvalid}, 5'b10100);
    @(negedge clk);
    chk("t5_orphan_clear", {s_bvalid, b_orphan}, 2'b00);
    chk("t5_no_b", b_log.size(), 10);

    // Test 6: reset in the middle of a stalled W
    @(negedge clk);
    wready_en = 1'b0;
    aw_q0.push_back(32'h250); w_q0.push_back(32'h999);
    k = 0;
    while (!s_wvalid && k < 20) begin @(negedge clk); k++; end
    chk("t6_w_inflight", s_wvalid, 1);
    #1;
    rst = 1'b0;
    #1;
    chk("t6_reset_immediate", ctrl_act(), 10'd0);
    clear_all();
    wready_en = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    aw_q0.push_back(32'h300); w_q0.push_back(32'h789);
    wait_b(1);
    chk("t6_awaddr", {aw_log_a.size(), aw_log_a[0]}, {32'd1, 32'h300});
    chk("t6_wdata", {w_log.size(), w_log[0]}, {32'd1, 32'h789});
    chk("t6_b_master", {b_log.size(), b_log[0]}, {32'd1, 32'd0});

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
